des_perm_engine: RTL

- Sequential, table-driven DES bit-permutation engine for the DES datapath.
- Replaces the fixed 32->48 E-expansion wiring with one shared unit that performs any of four FIPS 46-3 permutations: E, P, IP or IP^-1 (FP).
- The result is built BITS_PER_CYCLE output bits per clock, so area can be traded for latency in the scan-chain/SPI DES example.
- It uses a valid/ready handshake on both its input and its output.

---
 rtl/des_perm_pkg.sv | 75 +++++++
 rtl/des_perm_if.sv | 28 ++
 rtl/des_perm_lut.sv | 32 +++
 rtl/des_perm_engine.sv | 116 +++++++++++
 4 files changed

// File: rtl/des_perm_pkg.sv
// des_perm_pkg
// Shared definitions for the table-driven DES permutation engine:
//   - mode_t      : operation select (E, P, IP, FP)
//   - state_t     : engine control states
//   - width_of_mode() : number of result bits a mode produces
//   - E/P/IP/FP tables from FIPS 46-3
//
// Table entries are stored zero-based (FIPS source bit n is stored as n-1),
// so every entry fits in 6 bits, including source bit 64 of IP/FP.
package des_perm_pkg;

    typedef enum logic [1:0] {
        MODE_E  = 2'd0,
        MODE_P  = 2'd1,
        MODE_IP = 2'd2,
        MODE_FP = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [6:0] width_of_mode(input mode_t mode);
        case (mode)
            MODE_E:  return 7'd48;
            MODE_P:  return 7'd32;
            default: return 7'd64;
        endcase
    endfunction

    // Expansion E, 32 -> 48
    localparam logic [5:0] E_TABLE [1:48] = '{
        31,  0,  1,  2,  3,  4,  3,  4,
         5,  6,  7,  8,  7,  8,  9, 10,
        11, 12, 11, 12, 13, 14, 15, 16,
        15, 16, 17, 18, 19, 20, 19, 20,
        21, 22, 23, 24, 23, 24, 25, 26,
        27, 28, 27, 28, 29, 30, 31,  0
    };

    // Round permutation P, 32 -> 32
    localparam logic [5:0] P_TABLE [1:32] = '{
        15,  6, 19, 20, 28, 11, 27, 16,
         0, 14, 22, 25,  4, 17, 30,  9,
         1,  7, 23, 13, 31, 26,  2,  8,
        18, 12, 29,  5, 21, 10,  3, 24
    };

    // Initial permutation IP, 64 -> 64
    localparam logic [5:0] IP_TABLE [1:64] = '{
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7,
        56, 48, 40, 32, 24, 16,  8,  0,
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6
    };

    // Final permutation IP^-1, 64 -> 64
    localparam logic [5:0] FP_TABLE [1:64] = '{
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25,
        32,  0, 40,  8, 48, 16, 56, 24
    };

endpackage

// File: rtl/des_perm_if.sv
// des_perm_if
// Handshake bundle between a producer/consumer and des_perm_engine.
//   in_valid/in_ready/in_mode/in_data : request side
//   out_valid/out_ready/out_data      : result side
//   busy                              : engine is working or holding a result
// The engine connects through the slave modport, the driver through master.
interface des_perm_if;

    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [1:64] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:64] out_data;
    logic        busy;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/des_perm_lut.sv
// des_perm_lut
// Combinational table lookup: for a mode and a zero-based output bit index,
// returns the zero-based source bit index of the captured word.
//   mode      : permutation to look up
//   bit_index : output bit position, 0 = DES bit 1
//   src_index : source bit position, 0 = DES bit 1
// Positions past the mode's output width return 0.
module des_perm_lut
    import des_perm_pkg::*;
(
    input  mode_t       mode,
    input  logic [5:0]  bit_index,
    output logic [5:0]  src_index
);

    logic [6:0] pos;

    // Tables are indexed with FIPS 1-based output positions
    assign pos = {1'b0, bit_index} + 7'd1;

    always_comb begin
        src_index = '0;
        case (mode)
            MODE_E:  if (pos <= 7'd48) src_index = E_TABLE[pos[5:0]];
            MODE_P:  if (pos <= 7'd32) src_index = P_TABLE[pos[5:0]];
            MODE_IP: src_index = IP_TABLE[pos];
            MODE_FP: src_index = FP_TABLE[pos];
            default: src_index = '0;
        endcase
    end

endmodule

// File: rtl/des_perm_engine.sv
// des_perm_engine
// Sequential DES bit-permutation unit performing E, P, IP or FP.
// The result is assembled BITS_PER_CYCLE bits per clock from a frozen copy
// of the accepted word, trading lookup hardware for latency.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : des_perm_if slave (valid/ready request, valid/ready result, busy)
// Result is left-aligned in out_data; unused low bits read as zero.
module des_perm_engine
    import des_perm_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic      clk,
    input  logic      rst,
    des_perm_if.slave bus
);

    localparam int BPC_LOG2 = $clog2(BITS_PER_CYCLE);

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
              BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 16)) begin : g_bad_bpc
            $error("des_perm_engine: BITS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_t      state;
    state_t      state_next;
    mode_t       mode_reg;
    logic [0:63] src_word;
    logic [0:63] result;
    logic [0:63] result_next;
    logic [5:0]  chunk;
    logic [5:0]  base;
    logic        last_chunk;
    logic [5:0]  lane_bit [BITS_PER_CYCLE];
    logic [5:0]  lane_src [BITS_PER_CYCLE];

    // First output bit of the current chunk
    assign base = chunk << BPC_LOG2;

    // Last chunk is the one whose upper edge reaches the mode's width
    assign last_chunk = (({1'b0, base} + 7'(BITS_PER_CYCLE)) == width_of_mode(mode_reg));

    // One table lookup per output bit produced this cycle
    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_lane
        assign lane_bit[g] = base + 6'(g);

        des_perm_lut u_lut (
            .mode      (mode_reg),
            .bit_index (lane_bit[g]),
            .src_index (lane_src[g])
        );
    end

    // Merge this cycle's chunk into the partial result
    always_comb begin
        result_next = result;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            result_next[lane_bit[i]] = src_word[lane_src[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.in_valid)  state_next = ST_RUN;
            ST_RUN:  if (last_chunk)    state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture on acceptance, then fill the result one chunk per cycle.
    // The captured word and mode are never touched again until the next
    // acceptance, so input changes during RUN cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_word <= '0;
            mode_reg <= MODE_E;
            result   <= '0;
            chunk    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        src_word <= bus.in_data;
                        mode_reg <= mode_t'(bus.in_mode);
                        result   <= '0;
                        chunk    <= '0;
                    end
                end
                ST_RUN: begin
                    result <= result_next;
                    chunk  <= chunk + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.out_data  = result;

endmodule
